// File: rtl/stopwatch_button_ctrl_pkg.sv
// Shared definitions for the stopwatch control and counting stages:
// state codes, the state enum and the press_pulse bit ordering.
package stopwatch_pkg;

   localparam logic [2:0] ST_IDLE  = 3'b000;
   localparam logic [2:0] ST_RESET = 3'b001;
   localparam logic [2:0] ST_COUNT = 3'b010;
   localparam logic [2:0] ST_PAUSE = 3'b011;
   localparam logic [2:0] ST_STOP  = 3'b100;

   localparam int BTN_INICIAR = 0;
   localparam int BTN_RESET   = 1;
   localparam int BTN_CONTAR  = 2;
   localparam int BTN_PAUSAR  = 3;
   localparam int BTN_PARAR   = 4;
   localparam int NUM_BTN     = 5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_RESET = ST_RESET,
      S_COUNT = ST_COUNT,
      S_PAUSE = ST_PAUSE,
      S_STOP  = ST_STOP
   } state_e;

endpackage

// File: rtl/stopwatch_button_ctrl_if.sv
// Raw button inputs and the conditioned state/level/pulse outputs of the
// stopwatch control stage. The button driver is the master.
interface stopwatch_button_ctrl_if;

   logic       ButtonIniciar;
   logic       ButtonReset;
   logic       ButtonContar;
   logic       ButtonPausar;
   logic       ButtonParar;
   logic [2:0] state;
   logic       iniciar_level;
   logic [4:0] press_pulse;

   modport master (
      output ButtonIniciar, ButtonReset, ButtonContar, ButtonPausar, ButtonParar,
      input  state, iniciar_level, press_pulse
   );

   modport slave (
      input  ButtonIniciar, ButtonReset, ButtonContar, ButtonPausar, ButtonParar,
      output state, iniciar_level, press_pulse
   );

endinterface

// File: rtl/stopwatch_button_ctrl_debounce.sv
// One button channel: two-flop synchronizer, counting debounce filter and
// rising-edge press detector.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d, level_dly_q;
   logic             armed_q;
   logic [1:0]       vld_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The flip happens on the edge after the counter has registered
   // DEBOUNCE_CYCLES, so filtered rises DEBOUNCE_CYCLES+2 edges after capture.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // armed_q blocks a pulse for a button already held when reset was released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         cnt_q       <= '0;
         vld_q       <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         sync1_q     <= raw;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
         vld_q       <= {vld_q[0], 1'b1};
         if (vld_q[1] && !sync2_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign level = level_q;
   assign press = level_q & ~level_dly_q & armed_q;

endmodule

// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch control stage: five conditioned buttons feeding the command
// state machine whose registered code drives the counting core.
module stopwatch_button_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input logic              clk,
   input logic              rst_n,
   stopwatch_button_ctrl_if.slave bus
);

   logic [NUM_BTN-1:0] raw, level, press;
   logic               unused_levels;
   state_e             state_q, state_d;

   assign raw[BTN_INICIAR] = bus.ButtonIniciar;
   assign raw[BTN_RESET]   = bus.ButtonReset;
   assign raw[BTN_CONTAR]  = bus.ButtonContar;
   assign raw[BTN_PAUSAR]  = bus.ButtonPausar;
   assign raw[BTN_PARAR]   = bus.ButtonParar;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[gi]),
            .level (level[gi]),
            .press (press[gi])
         );
      end
   endgenerate

   assign unused_levels = ^level[NUM_BTN-1:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Reset outranks Parar, which outranks Pausar, which outranks Contar.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_STOP: begin
            if (press[BTN_RESET]) state_d = S_RESET;
         end
         S_RESET: begin
            if (press[BTN_RESET])       state_d = S_RESET;
            else if (press[BTN_CONTAR]) state_d = S_COUNT;
         end
         S_COUNT: begin
            if (press[BTN_RESET])       state_d = S_RESET;
            else if (press[BTN_PARAR])  state_d = S_STOP;
            else if (press[BTN_PAUSAR]) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (press[BTN_RESET])       state_d = S_RESET;
            else if (press[BTN_PARAR])  state_d = S_STOP;
            else if (press[BTN_CONTAR]) state_d = S_COUNT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.state         = state_q;
   assign bus.iniciar_level = level[BTN_INICIAR];
   assign bus.press_pulse   = press;

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed bench for stopwatch_button_ctrl with DEBOUNCE_CYCLES=4.
module tb_stopwatch_button_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] btn;
   int         n_checks;
   int         n_pass;

   stopwatch_button_ctrl_if bus ();

   assign bus.ButtonIniciar = btn[0];
   assign bus.ButtonReset   = btn[1];
   assign bus.ButtonContar  = btn[2];
   assign bus.ButtonPausar  = btn[3];
   assign bus.ButtonParar   = btn[4];

   stopwatch_button_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the masked buttons for 'hold' cycles, releases them and lets the
   // release debounce; returns the number of pulse bits seen.
   task automatic press_btns(input logic [4:0] mask, input int hold, output int pulses);
      pulses = 0;
      btn = btn | mask;
      repeat (hold) begin
         tick();
         pulses += $countones(bus.press_pulse);
      end
      btn = btn & ~mask;
      repeat (10) begin
         tick();
         pulses += $countones(bus.press_pulse);
      end
   endtask

   task automatic test_reset();
      btn   = 5'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (bus.state !== 3'b000) $display("FAIL reset_state: got %b want 000", bus.state);
      else n_pass++;
      n_checks++;
      if (bus.iniciar_level !== 1'b0) $display("FAIL reset_iniciar: got %b want 0", bus.iniciar_level);
      else n_pass++;
      n_checks++;
      if (bus.press_pulse !== 5'b0) $display("FAIL reset_pulse: got %b want 00000", bus.press_pulse);
      else n_pass++;
      rst_n = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (bus.state !== 3'b000) $display("FAIL reset_idle_after: got %b want 000", bus.state);
      else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_walk();
      int p;
      btn[1] = 1'b1;
      repeat (6) tick();
      n_checks++;
      if (bus.press_pulse !== 5'b0) $display("FAIL walk_early_pulse: got %b want 00000", bus.press_pulse);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.press_pulse !== 5'b00010 || bus.state !== 3'b000)
         $display("FAIL walk_pulse_edge6: got pulse %b state %b want 00010 000", bus.press_pulse, bus.state);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.state !== 3'b001 || bus.press_pulse !== 5'b0)
         $display("FAIL walk_state_edge7: got state %b pulse %b want 001 00000", bus.state, bus.press_pulse);
      else n_pass++;
      repeat (2) tick();
      btn[1] = 1'b0;
      repeat (10) tick();

      press_btns(5'b00100, 10, p);
      n_checks++;
      if (bus.state !== 3'b010 || p != 1) $display("FAIL walk_contar: got state %b pulses %0d want 010 1", bus.state, p);
      else n_pass++;
      press_btns(5'b01000, 10, p);
      n_checks++;
      if (bus.state !== 3'b011 || p != 1) $display("FAIL walk_pausar: got state %b pulses %0d want 011 1", bus.state, p);
      else n_pass++;
      press_btns(5'b00100, 10, p);
      n_checks++;
      if (bus.state !== 3'b010 || p != 1) $display("FAIL walk_resume: got state %b pulses %0d want 010 1", bus.state, p);
      else n_pass++;
      press_btns(5'b10000, 10, p);
      n_checks++;
      if (bus.state !== 3'b100 || p != 1) $display("FAIL walk_parar: got state %b pulses %0d want 100 1", bus.state, p);
      else n_pass++;
      $display("test_walk done state=%b", bus.state);
   endtask

   task automatic test_bounce();
      int p;
      press_btns(5'b00010, 10, p);
      n_checks++;
      if (bus.state !== 3'b001) $display("FAIL bounce_setup: got %b want 001", bus.state);
      else n_pass++;
      p = 0;
      repeat (6) begin
         btn[2] = 1'b1;
         repeat (3) begin tick(); p += $countones(bus.press_pulse); end
         btn[2] = 1'b0;
         tick();
         p += $countones(bus.press_pulse);
      end
      repeat (3) begin tick(); p += $countones(bus.press_pulse); end
      n_checks++;
      if (p != 0 || bus.state !== 3'b001) $display("FAIL bounce_reject: got pulses %0d state %b want 0 001", p, bus.state);
      else n_pass++;
      press_btns(5'b00100, 6, p);
      n_checks++;
      if (p != 1 || bus.state !== 3'b010) $display("FAIL bounce_hold6: got pulses %0d state %b want 1 010", p, bus.state);
      else n_pass++;
      $display("test_bounce done state=%b", bus.state);
   endtask

   task automatic test_ignored();
      int p;
      #2 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      press_btns(5'b00100, 8, p);
      n_checks++;
      if (bus.state !== 3'b000 || p != 1) $display("FAIL idle_contar: got state %b pulses %0d want 000 1", bus.state, p);
      else n_pass++;
      press_btns(5'b01000, 8, p);
      n_checks++;
      if (bus.state !== 3'b000 || p != 1) $display("FAIL idle_pausar: got state %b pulses %0d want 000 1", bus.state, p);
      else n_pass++;
      press_btns(5'b10000, 8, p);
      n_checks++;
      if (bus.state !== 3'b000 || p != 1) $display("FAIL idle_parar: got state %b pulses %0d want 000 1", bus.state, p);
      else n_pass++;
      press_btns(5'b00010, 8, p);
      press_btns(5'b00100, 8, p);
      press_btns(5'b10000, 8, p);
      n_checks++;
      if (bus.state !== 3'b100) $display("FAIL ign_to_stop: got %b want 100", bus.state);
      else n_pass++;
      press_btns(5'b00100, 8, p);
      n_checks++;
      if (bus.state !== 3'b100) $display("FAIL stop_contar: got %b want 100", bus.state);
      else n_pass++;
      press_btns(5'b00010, 8, p);
      n_checks++;
      if (bus.state !== 3'b001) $display("FAIL stop_reset: got %b want 001", bus.state);
      else n_pass++;
      $display("test_ignored done state=%b", bus.state);
   endtask

   task automatic test_simultaneous();
      int p;
      press_btns(5'b00100, 8, p);
      press_btns(5'b11000, 8, p);
      n_checks++;
      if (bus.state !== 3'b100 || p != 2) $display("FAIL sim_pausar_parar: got state %b pulses %0d want 100 2", bus.state, p);
      else n_pass++;
      press_btns(5'b00010, 8, p);
      press_btns(5'b00100, 8, p);
      press_btns(5'b01000, 8, p);
      n_checks++;
      if (bus.state !== 3'b011) $display("FAIL sim_setup_pause: got %b want 011", bus.state);
      else n_pass++;
      press_btns(5'b00110, 8, p);
      n_checks++;
      if (bus.state !== 3'b001 || p != 2) $display("FAIL sim_reset_contar: got state %b pulses %0d want 001 2", bus.state, p);
      else n_pass++;
      $display("test_simultaneous done state=%b", bus.state);
   endtask

   task automatic test_held();
      int p;
      p = 0;
      btn[2] = 1'b1;
      repeat (50) begin tick(); p += $countones(bus.press_pulse); end
      n_checks++;
      if (p != 1 || bus.state !== 3'b010) $display("FAIL held_single: got pulses %0d state %b want 1 010", p, bus.state);
      else n_pass++;
      press_btns(5'b01000, 8, p);
      n_checks++;
      if (bus.state !== 3'b011 || p != 1) $display("FAIL held_pausar: got state %b pulses %0d want 011 1", bus.state, p);
      else n_pass++;
      btn[2] = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (bus.state !== 3'b011) $display("FAIL held_release: got %b want 011", bus.state);
      else n_pass++;
      press_btns(5'b00100, 8, p);
      n_checks++;
      if (bus.state !== 3'b010 || p != 1) $display("FAIL held_repress: got state %b pulses %0d want 010 1", bus.state, p);
      else n_pass++;
      $display("test_held done state=%b", bus.state);
   endtask

   task automatic test_async_reset();
      int p;
      btn[0] = 1'b1;
      repeat (10) tick();
      n_checks++;
      if (bus.iniciar_level !== 1'b1 || bus.state !== 3'b010)
         $display("FAIL iniciar_level: got level %b state %b want 1 010", bus.iniciar_level, bus.state);
      else n_pass++;
      btn[3] = 1'b1;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.state !== 3'b000 || bus.iniciar_level !== 1'b0 || bus.press_pulse !== 5'b0)
         $display("FAIL async_reset: got state %b level %b pulse %b want 000 0 00000",
                  bus.state, bus.iniciar_level, bus.press_pulse);
      else n_pass++;
      repeat (2) tick();
      rst_n = 1'b1;
      p = 0;
      repeat (20) begin tick(); p += $countones(bus.press_pulse); end
      n_checks++;
      if (p != 0 || bus.state !== 3'b000) $display("FAIL held_through_reset: got pulses %0d state %b want 0 000", p, bus.state);
      else n_pass++;
      n_checks++;
      if (bus.iniciar_level !== 1'b1) $display("FAIL iniciar_after_reset: got %b want 1", bus.iniciar_level);
      else n_pass++;
      btn = 5'b0;
      repeat (12) tick();
      press_btns(5'b00010, 8, p);
      n_checks++;
      if (bus.state !== 3'b001 || p != 1) $display("FAIL rearm_reset: got state %b pulses %0d want 001 1", bus.state, p);
      else n_pass++;
      $display("test_async_reset done state=%b", bus.state);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      btn      = 5'b0;
      rst_n    = 1'b0;
      test_reset();
      test_walk();
      test_bounce();
      test_ignored();
      test_simultaneous();
      test_held();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
